// File: rtl/regfile_dump_pkg.sv
// regfile_dump_pkg: shared types and sizing constants for the register-file
// dump engine (FSM state encoding, register count, address/data/byte widths).
package regfile_dump_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned BYTE_W   = 8;

endpackage

// File: rtl/regfile_dump_if.sv
// regfile_dump_if: valid/ready byte stream from the dump engine to its sink
// (UART or debug link).
//   tx_data  : current byte, driven by master
//   tx_valid : byte offered, driven by master
//   tx_ready : sink accepts byte on a rising edge with tx_valid high
interface regfile_dump_if;
  import regfile_dump_pkg::*;

  logic [BYTE_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/regfile_dump.sv
// regfile_dump: walks registers FIRST_REG..LAST_REG through one register-file
// read port and streams each 32-bit word as four bytes, MSB first.
// Ports:
//   clk       : system clock, all state on rising edge
//   rst       : synchronous active-low reset
//   start     : dump request, honoured only in IDLE
//   abort     : synchronous cancel, wins over everything but reset
//   busy      : high in LOAD/SEND/DONE
//   done      : one-cycle pulse after the last byte of LAST_REG is accepted
//   rf_raddr  : registered register-file read address
//   rf_rdata  : register-file read data (combinational from rf_raddr)
//   tx        : byte stream master (tx_data/tx_valid/tx_ready)
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  regfile_dump_if.master    tx
);

  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(LAST_REG);

  state_t            state;
  logic [DATA_W-1:0] shift;
  logic [1:0]        byte_cnt;
  logic              handshake;

  assign handshake = tx.tx_valid & tx.tx_ready;

  // The outgoing byte is always the top of the shift register, so it stays
  // stable through any number of stalled cycles without a separate register.
  assign tx.tx_data = shift[DATA_W-1 -: BYTE_W];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      rf_raddr    <= FIRST_ADDR;
      tx.tx_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      byte_cnt    <= '0;
      shift       <= '0;
    end else if (abort) begin
      state       <= IDLE;
      rf_raddr    <= FIRST_ADDR;
      tx.tx_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      byte_cnt    <= '0;
      shift       <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          rf_raddr <= FIRST_ADDR;
          if (start) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          shift       <= rf_rdata;
          byte_cnt    <= '0;
          tx.tx_valid <= 1'b1;
          state       <= SEND;
        end
        SEND: begin
          if (handshake) begin
            shift    <= {shift[DATA_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              tx.tx_valid <= 1'b0;
              if (rf_raddr == LAST_ADDR) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                rf_raddr <= rf_raddr + 5'd1;
                state    <= LOAD;
              end
            end
          end
        end
        DONE: begin
          rf_raddr <= FIRST_ADDR;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: directed self-checking bench for regfile_dump.
// dut_a dumps the full 0..31 range, dut_b dumps 5..6 for the backpressure case.
module tb_regfile_dump;
  import regfile_dump_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start_a, abort_a, busy_a, done_a, rdy_a;
  logic        start_b, abort_b, busy_b, done_b, rdy_b;
  logic [4:0]  raddr_a, raddr_b;
  logic [31:0] rdata_a, rdata_b;
  logic [31:0] regs [NUM_REGS];

  regfile_dump_if ifa ();
  regfile_dump_if ifb ();

  assign ifa.tx_ready = rdy_a;
  assign ifb.tx_ready = rdy_b;
  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

  regfile_dump #(.FIRST_REG(0), .LAST_REG(31)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
    .busy(busy_a), .done(done_a), .rf_raddr(raddr_a), .rf_rdata(rdata_a),
    .tx(ifa.master)
  );

  regfile_dump #(.FIRST_REG(5), .LAST_REG(6)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
    .busy(busy_b), .done(done_b), .rf_raddr(raddr_b), .rf_rdata(rdata_b),
    .tx(ifb.master)
  );

  int   errors = 0;
  int   checks = 0;
  logic [7:0] got [$];
  int   got_edge [$];
  int   done_cnt, done_edge, exit_n;
  logic finished;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int first, input int idx);
    logic [31:0] w;
    if (first + idx / 4 > 31) return 8'h00;
    w = regs[first + idx / 4];
    return w[31 - 8 * (idx % 4) -: 8];
  endfunction

  task automatic drive(input int which, input logic st, input logic ab, input logic rd);
    if (which == 0) begin
      start_a = st; abort_a = ab; rdy_a = rd;
    end else begin
      start_b = st; abort_b = ab; rdy_b = rd;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start, then follows the dump one cycle at a time. n counts edges
  // after the start-sampling edge E0; a handshake seen while observing at n
  // happens on edge n+1. Stops after done with busy low, or at the cycle
  // after an injected abort/reset.
  task automatic collect(input int which, input int period, input int max_cyc,
                         input bit spam, input int abort_at, input int rst_at);
    int first, stop_at;
    logic v, bz, dn, rd;
    logic [7:0] d;
    first   = (which == 0) ? 0 : 5;
    stop_at = (abort_at >= 0) ? abort_at + 1 : ((rst_at >= 0) ? rst_at + 1 : -1);
    got.delete();
    got_edge.delete();
    done_cnt = 0; done_edge = -1; exit_n = -1; finished = 1'b0;
    drive(which, 1'b1, 1'b0, 1'b0);
    tick();
    for (int n = 0; n < max_cyc && !finished; n++) begin
      v  = (which == 0) ? ifa.tx_valid : ifb.tx_valid;
      d  = (which == 0) ? ifa.tx_data  : ifb.tx_data;
      bz = (which == 0) ? busy_a : busy_b;
      dn = (which == 0) ? done_a : done_b;
      if (n == 0) begin
        check("busy_in_load", bz, 1);
        check("valid_in_load", v, 0);
      end
      if (v) check($sformatf("tx_data[%0d]", got.size()), d, exp_byte(first, got.size()));
      if (dn) begin
        done_cnt++;
        done_edge = n;
      end
      if ((stop_at < 0 && done_cnt > 0 && !bz) || n == stop_at) begin
        finished = 1'b1;
        exit_n = n;
      end else begin
        rd = (period <= 1) || (n % period == period - 1);
        if (n == abort_at || n == rst_at) rd = 1'b0;
        drive(which, spam && (n % 7 == 3), (n == abort_at), rd);
        rst = !(n == rst_at);
        if (v && rd) begin
          got.push_back(d);
          got_edge.push_back(n + 1);
        end
        tick();
      end
    end
    drive(which, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    check("no_timeout", finished, 1);
  endtask

  initial begin
    int vcnt;
    for (int k = 0; k < 32; k++) regs[k] = 32'h1000_0000 + k;
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0, 1'b0);

    // Reset, then idle
    tick();
    tick();
    check("rst_valid", ifa.tx_valid, 0);
    check("rst_data", ifa.tx_data, 8'h00);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_raddr", raddr_a, 5'd0);
    check("rst_raddr_b", raddr_b, 5'd5);
    rst = 1'b1;
    rdy_a = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ifa.tx_valid || busy_a) vcnt++;
    end
    check("idle_no_valid", vcnt, 0);

    // Full dump with tx_ready held high
    collect(0, 1, 200, 1'b0, -1, -1);
    check("full_bytes", got.size(), 128);
    if (got.size() == 128) begin
      check("full_b0", got[0], 8'h10);
      check("full_b1", got[1], 8'h00);
      check("full_b3", got[3], 8'h00);
      check("full_b124", got[124], 8'h10);
      check("full_b127", got[127], 8'h1F);
      check("full_first_edge", got_edge[0], 2);
      check("full_reg1_edge", got_edge[4], 7);
      check("full_last_edge", got_edge[127], 160);
    end
    check("full_done_cnt", done_cnt, 1);
    check("full_done_edge", done_edge, 160);
    check("full_idle_edge", exit_n, 161);
    check("full_raddr_back", raddr_a, 5'd0);

    // Backpressure on range 5..6
    regs[5] = 32'hDEAD_BEEF;
    regs[6] = 32'h0BAD_F00D;
    collect(1, 3, 200, 1'b0, -1, -1);
    check("bp_bytes", got.size(), 8);
    if (got.size() == 8) begin
      check("bp_b0", got[0], 8'hDE);
      check("bp_b1", got[1], 8'hAD);
      check("bp_b2", got[2], 8'hBE);
      check("bp_b3", got[3], 8'hEF);
      check("bp_b4", got[4], 8'h0B);
      check("bp_b7", got[7], 8'h0D);
    end
    check("bp_done_cnt", done_cnt, 1);
    check("bp_raddr_back", raddr_b, 5'd5);
    regs[5] = 32'h1000_0005;
    regs[6] = 32'h1000_0006;

    // Abort after 2nd byte of reg 3 (sampled on E19)
    collect(0, 1, 100, 1'b0, 18, -1);
    check("ab_bytes", got.size(), 14);
    check("ab_valid", ifa.tx_valid, 0);
    check("ab_busy", busy_a, 0);
    check("ab_done", done_a, 0);
    check("ab_raddr", raddr_a, 5'd0);
    check("ab_done_cnt", done_cnt, 0);
    vcnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done_a || busy_a) vcnt++;
    end
    check("ab_quiet", vcnt, 0);
    collect(0, 1, 200, 1'b0, -1, -1);
    check("ab_restart_bytes", got.size(), 128);
    if (got.size() > 3) begin
      check("ab_restart_b0", got[0], 8'h10);
      check("ab_restart_b3", got[3], 8'h00);
    end
    check("ab_restart_done", done_cnt, 1);

    // Extra start pulses while busy
    collect(0, 1, 200, 1'b1, -1, -1);
    check("spam_bytes", got.size(), 128);
    check("spam_done_cnt", done_cnt, 1);
    check("spam_idle_edge", exit_n, 161);

    // start and abort together in IDLE
    vcnt = 0;
    drive(0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (busy_a || ifa.tx_valid) vcnt++;
    end
    drive(0, 1'b0, 1'b0, 1'b1);
    tick();
    if (busy_a || ifa.tx_valid) vcnt++;
    check("start_abort_idle", vcnt, 0);

    // Reset during SEND of reg 10 (sampled on E54)
    collect(0, 1, 100, 1'b0, -1, 53);
    check("mr_bytes", got.size(), 42);
    check("mr_valid", ifa.tx_valid, 0);
    check("mr_data", ifa.tx_data, 8'h00);
    check("mr_busy", busy_a, 0);
    check("mr_done", done_a, 0);
    check("mr_raddr", raddr_a, 5'd0);
    collect(0, 1, 200, 1'b0, -1, -1);
    check("mr_restart_bytes", got.size(), 128);
    if (got.size() > 0) check("mr_restart_b0", got[0], 8'h10);
    check("mr_restart_done", done_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
